// File: rtl/l2_msg_pkg.sv
// Shared definitions for the L2 message-input front end: field widths,
// memory-ack message types, arbiter state and the pipeline payload record.
package l2_msg_pkg;

   localparam int unsigned TYPE_W = 8;
   localparam int unsigned SRC_W  = 6;
   localparam int unsigned TAG_W  = 26;
   localparam int unsigned DATA_W = 64;

   localparam logic [TYPE_W-1:0] MSG_LOAD_MEM_ACK  = 8'h18;
   localparam logic [TYPE_W-1:0] MSG_STORE_MEM_ACK = 8'h19;

   typedef enum logic {
      RUN      = 1'b0,
      WAIT_MEM = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [TYPE_W-1:0] mtype;
      logic [SRC_W-1:0]  source;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } msg_t;

   function automatic logic is_mem_ack(input logic [TYPE_W-1:0] mtype);
      return (mtype == MSG_LOAD_MEM_ACK) || (mtype == MSG_STORE_MEM_ACK);
   endfunction

endpackage

// File: rtl/l2_msg_out_reg.sv
// Single-entry valid/ready output register holding one pipeline message
// plus the flag recording which input channel it came from.
module l2_msg_out_reg
   import l2_msg_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  msg_t in_msg,
   input  logic in_from_mem,
   output logic load,
   output logic out_valid,
   input  logic out_ready,
   output msg_t out_msg,
   output logic out_from_mem
);

   assign load = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_msg      <= '0;
         out_from_mem <= 1'b0;
      end else if (load) begin
         out_valid <= in_valid;
         // Payload keeps its last value when the register drains empty
         if (in_valid) begin
            out_msg      <= in_msg;
            out_from_mem <= in_from_mem;
         end
      end
   end

endmodule

// File: rtl/l2_msg_in_arbiter.sv
// Merges core requests (msg1) and memory responses (msg3) into one registered
// pipeline stream, blocking msg1 while a memory transaction is outstanding.
module l2_msg_in_arbiter
   import l2_msg_pkg::*;
#(
   parameter int unsigned MAX_STARVE = 4,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              msg1_valid,
   output logic              msg1_ready,
   input  logic [TYPE_W-1:0] msg1_type,
   input  logic [SRC_W-1:0]  msg1_source,
   input  logic [TAG_W-1:0]  msg1_tag,
   input  logic [DATA_W-1:0] msg1_data,
   input  logic              msg3_valid,
   output logic              msg3_ready,
   input  logic [TYPE_W-1:0] msg3_type,
   input  logic [SRC_W-1:0]  msg3_source,
   input  logic [TAG_W-1:0]  msg3_tag,
   input  logic [DATA_W-1:0] msg3_data,
   output logic              pipe_valid,
   input  logic              pipe_ready,
   output logic [TYPE_W-1:0] pipe_type,
   output logic [SRC_W-1:0]  pipe_source,
   output logic [TAG_W-1:0]  pipe_tag,
   output logic [DATA_W-1:0] pipe_data,
   output logic              pipe_from_mem,
   input  logic              mem_req_issued,
   output logic              wait_mem,
   output logic              mem_timeout,
   output logic              err_double_req
);

   localparam logic [3:0]  STARVE_LIM  = 4'(MAX_STARVE);
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

   arb_state_t  state, state_next;
   logic [3:0]  starve_cnt;
   logic [15:0] timeout_cnt;
   logic        load, force1, acc1, acc3, ack_acc;
   logic        set_err, timeout_restart;
   msg_t        in_msg, out_msg;

   assign wait_mem = (state == WAIT_MEM);
   assign force1   = (starve_cnt == STARVE_LIM);

   // msg3 ready is withheld only when msg1 actually takes the slot, so the
   // two channels are never accepted in the same cycle
   assign msg1_ready = load && !wait_mem && (!msg3_valid || force1);
   assign acc1       = msg1_valid && msg1_ready;
   assign msg3_ready = load && !acc1;
   assign acc3       = msg3_valid && msg3_ready;
   assign ack_acc    = acc3 && is_mem_ack(msg3_type);

   assign in_msg = acc1 ? '{mtype: msg1_type, source: msg1_source, tag: msg1_tag, data: msg1_data}
                        : '{mtype: msg3_type, source: msg3_source, tag: msg3_tag, data: msg3_data};

   l2_msg_out_reg u_out_reg (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (acc1 || acc3),
      .in_msg       (in_msg),
      .in_from_mem  (acc3),
      .load         (load),
      .out_valid    (pipe_valid),
      .out_ready    (pipe_ready),
      .out_msg      (out_msg),
      .out_from_mem (pipe_from_mem)
   );

   assign pipe_type   = out_msg.mtype;
   assign pipe_source = out_msg.source;
   assign pipe_tag    = out_msg.tag;
   assign pipe_data   = out_msg.data;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   always_comb begin
      state_next      = state;
      set_err         = 1'b0;
      timeout_restart = 1'b0;
      case (state)
         RUN: begin
            if (mem_req_issued) state_next = WAIT_MEM;
         end
         WAIT_MEM: begin
            if (ack_acc && mem_req_issued) timeout_restart = 1'b1;
            else if (ack_acc)              state_next = RUN;
            else if (mem_req_issued)       set_err = 1'b1;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt     <= '0;
         timeout_cnt    <= '0;
         mem_timeout    <= 1'b0;
         err_double_req <= 1'b0;
      end else begin
         if (!wait_mem) begin
            if (!msg1_valid || acc1)                  starve_cnt <= '0;
            else if (acc3 && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
         end

         if (state_next == RUN || timeout_restart)     timeout_cnt <= '0;
         else if (wait_mem && timeout_cnt != '1)       timeout_cnt <= timeout_cnt + 16'd1;

         if (wait_mem && timeout_cnt == TIMEOUT_LIM) mem_timeout <= 1'b1;
         if (set_err)                                err_double_req <= 1'b1;
      end
   end

endmodule

// File: tb/tb_l2_msg_in_arbiter.sv
// Directed and randomized bench for l2_msg_in_arbiter, checked cycle by cycle
// against a transaction-level reference model of the arbitration rules.
module tb_l2_msg_in_arbiter;

   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        msg1_valid, msg1_ready, msg3_valid, msg3_ready;
   logic [7:0]  msg1_type, msg3_type, pipe_type;
   logic [5:0]  msg1_source, msg3_source, pipe_source;
   logic [25:0] msg1_tag, msg3_tag, pipe_tag;
   logic [63:0] msg1_data, msg3_data, pipe_data;
   logic        pipe_valid, pipe_ready, pipe_from_mem;
   logic        mem_req_issued, wait_mem, mem_timeout, err_double_req;

   always #5 clk = ~clk;

   l2_msg_in_arbiter #(.MAX_STARVE(MAXS), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .msg1_valid(msg1_valid), .msg1_ready(msg1_ready), .msg1_type(msg1_type),
      .msg1_source(msg1_source), .msg1_tag(msg1_tag), .msg1_data(msg1_data),
      .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
      .msg3_source(msg3_source), .msg3_tag(msg3_tag), .msg3_data(msg3_data),
      .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_type(pipe_type),
      .pipe_source(pipe_source), .pipe_tag(pipe_tag), .pipe_data(pipe_data),
      .pipe_from_mem(pipe_from_mem), .mem_req_issued(mem_req_issued),
      .wait_mem(wait_mem), .mem_timeout(mem_timeout), .err_double_req(err_double_req)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: outstanding-memory flag, msg3 streak while msg1 waits,
   // cycles spent waiting, the one held pipeline message and the sticky flags
   bit           m_wait, m_pv, m_pfm, m_to, m_err;
   int           m_streak, m_wcnt;
   logic [103:0] m_pmsg;
   logic [103:0] snap;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_clear();
      m_wait = 0; m_pv = 0; m_pfm = 0; m_to = 0; m_err = 0;
      m_streak = 0; m_wcnt = 0; m_pmsg = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      msg1_valid = 0; msg3_valid = 0; pipe_ready = 0; mem_req_issued = 0;
      msg1_type = '0; msg1_source = '0; msg1_tag = '0; msg1_data = '0;
      msg3_type = '0; msg3_source = '0; msg3_tag = '0; msg3_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      chk("rst_pipe_valid", pipe_valid, 0);
      chk("rst_payload", {pipe_type, pipe_source, pipe_tag, pipe_data}, 0);
      chk("rst_wait_mem", wait_mem, 0);
      chk("rst_timeout", mem_timeout, 0);
      chk("rst_err", err_double_req, 0);
   endtask

   // One clock cycle: drive inputs, compare all outputs with the model, advance the model
   task automatic step(input bit v1, input logic [7:0] t1, input logic [25:0] g1,
                       input bit v3, input logic [7:0] t3, input logic [25:0] g3,
                       input bit pr, input bit mr);
      bit load, e1r, e3r, take1, take3, ack;
      logic [103:0] p1, p3;
      @(negedge clk);
      msg1_valid = v1; msg1_type = t1; msg1_tag = g1;
      msg1_source = 6'($urandom); msg1_data = {$urandom, $urandom};
      msg3_valid = v3; msg3_type = t3; msg3_tag = g3;
      msg3_source = 6'($urandom); msg3_data = {$urandom, $urandom};
      pipe_ready = pr; mem_req_issued = mr;
      #1;
      p1 = {msg1_type, msg1_source, msg1_tag, msg1_data};
      p3 = {msg3_type, msg3_source, msg3_tag, msg3_data};
      load  = !m_pv || pr;
      e1r   = load && !m_wait && (!v3 || m_streak == MAXS);
      take1 = v1 && e1r;
      e3r   = load && !take1;
      take3 = v3 && e3r;
      chk("msg1_ready", msg1_ready, e1r);
      chk("msg3_ready", msg3_ready, e3r);
      chk("pipe_valid", pipe_valid, m_pv);
      chk("pipe_payload", {pipe_type, pipe_source, pipe_tag, pipe_data}, m_pmsg);
      chk("pipe_from_mem", pipe_from_mem, m_pfm);
      chk("wait_mem", wait_mem, m_wait);
      chk("mem_timeout", mem_timeout, m_to);
      chk("err_double_req", err_double_req, m_err);

      ack = take3 && (t3 == 8'h18 || t3 == 8'h19);
      if (m_wait && m_wcnt == TO) m_to = 1;
      if (take1)      begin m_pv = 1; m_pmsg = p1; m_pfm = 0; end
      else if (take3) begin m_pv = 1; m_pmsg = p3; m_pfm = 1; end
      else if (load)  m_pv = 0;
      if (!m_wait) begin
         if (!v1 || take1)                 m_streak = 0;
         else if (take3 && m_streak < MAXS) m_streak++;
         if (mr) m_wait = 1;
         m_wcnt = 0;
      end else if (ack) begin
         if (!mr) m_wait = 0;
         m_wcnt = 0;
      end else begin
         if (mr) m_err = 1;
         if (m_wcnt < 65535) m_wcnt++;
      end
   endtask

   task automatic idle(input bit mr);
      step(0, 8'h00, 26'h0, 0, 8'h00, 26'h0, 1, mr);
   endtask

   initial begin
      rst = 1'b1;
      do_reset();

      // Single core request, latency 1
      step(1, 8'h01, 26'h123, 0, 8'h00, 26'h0, 1, 0);
      chk("t1_msg1_ready", msg1_ready, 1);
      idle(0);
      chk("t1_pipe_valid", pipe_valid, 1);
      chk("t1_pipe_tag", pipe_tag, 26'h123);
      chk("t1_from_mem", pipe_from_mem, 0);

      // Both channels busy: four msg3 grants then one forced msg1 grant
      for (int k = 0; k < 15; k++) begin
         step(1, 8'h02, 26'(k), 1, 8'h05, 26'(k + 100), 1, 0);
         chk("t2_grant_msg1", msg1_ready, (k % 5) == 4);
         chk("t2_exclusive", msg1_ready && msg3_ready, 0);
      end

      // Back-pressure holds the output stable and stalls both inputs
      for (int k = 0; k < 3; k++) begin
         step(1, 8'h03, 26'h3, 1, 8'h06, 26'h6, 0, 0);
         if (k == 0) snap = {pipe_type, pipe_source, pipe_tag, pipe_data};
         chk("t3_stall_ready", msg1_ready || msg3_ready, 0);
         chk("t3_stable", {pipe_type, pipe_source, pipe_tag, pipe_data}, snap);
      end
      step(1, 8'h03, 26'h3, 1, 8'h06, 26'h6, 1, 0);
      chk("t3_drain_accept", msg1_ready || msg3_ready, 1);

      // Outstanding memory transaction blocks msg1 until an ack is accepted
      idle(1);
      step(1, 8'h04, 26'h44, 1, 8'h05, 26'h55, 1, 0);
      chk("t4_wait", wait_mem, 1);
      chk("t4_msg1_blocked", msg1_ready, 0);
      chk("t4_msg3_fwd", msg3_ready, 1);
      step(1, 8'h04, 26'h44, 1, 8'h19, 26'h66, 1, 0);
      chk("t4_still_wait", wait_mem, 1);
      step(1, 8'h04, 26'h44, 0, 8'h00, 26'h0, 1, 0);
      chk("t4_released", wait_mem, 0);
      chk("t4_msg1_ok", msg1_ready, 1);

      // Timeout after TO+1 waiting cycles, then a double request
      idle(1);
      for (int k = 1; k <= 10; k++) begin
         idle(0);
         chk("t5_timeout", mem_timeout, k >= 10);
      end
      idle(1);
      idle(0);
      chk("t5_double_req", err_double_req, 1);
      do_reset();

      // Ack and new request together: stay waiting, timeout count restarts
      idle(1);
      step(0, 8'h00, 26'h0, 1, 8'h18, 26'h77, 1, 1);
      for (int k = 1; k <= 10; k++) begin
         idle(0);
         chk("t6_wait", wait_mem, 1);
         chk("t6_timeout", mem_timeout, k >= 10);
      end

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 800; k++) begin
         logic [7:0] t3r;
         t3r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) t3r = ($urandom_range(0, 1) == 0) ? 8'h18 : 8'h19;
         step($urandom_range(0, 2) != 0, 8'($urandom), 26'($urandom),
              $urandom_range(0, 2) != 0, t3r, 26'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         if (k == 400) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
